// File: rtl/ps2_scancode_pkg.sv
// Shared PS/2 Set-2 scancode constants, decoder state encoding and event type
// for the make-code filter.
package ps2_scancode_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PREFIX_PAUSE = 8'hE1;

  localparam logic [7:0] PS2_RESP_ERR0    = 8'h00;
  localparam logic [7:0] PS2_RESP_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_RESP_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESP_BAT_ERR = 8'hFC;
  localparam logic [7:0] PS2_RESP_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_RESP_ERR1    = 8'hFF;

  localparam int PAUSE_TAIL_LEN = 7;
  localparam int SKIP_W         = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_PAUSE
  } dec_state_e;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_response(input logic [7:0] b);
    case (b)
      PS2_RESP_ERR0, PS2_RESP_BAT_OK, PS2_RESP_ECHO, PS2_RESP_ACK,
      PS2_RESP_BAT_ERR, PS2_RESP_RESEND, PS2_RESP_ERR1: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/scancode_fifo.sv
// Show-ahead FIFO of {ext, code} key events with occupancy reporting.
// A push on a full FIFO is accepted only if a pop frees a slot in the same cycle.
module scancode_fifo
  import ps2_scancode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  key_event_t               wr_data,
  input  logic                     pop,
  output key_event_t               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  key_event_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_fire;
  logic            pop_fire;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign pop_fire  = pop && !empty;
  assign push_fire = push && (!full || pop_fire);

  // Head is forced to zero when empty so stale entries never leak out.
  assign rd_data   = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; occupancy is tracked by the pointers
  // and count, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_make_code_filter.sv
// Reduces a raw PS/2 Set-2 byte stream to one queued event per key press.
// Optional auto-repeat suppression is enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_make_code_filter
  import ps2_scancode_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_data_en,
  input  logic [7:0]                    ps2_data,
  input  logic                          key_ready,
  input  logic                          clear_overflow,
  output logic                          key_valid,
  output logic [7:0]                    key_code,
  output logic                          key_extended,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  dec_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              make_fire;
  logic              brk_fire;
  key_event_t        evt;
  logic              push_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop_fire;
  key_event_t        head;

  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values; = here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    make_fire = 1'b0;
    brk_fire  = 1'b0;
    evt       = '{ext: 1'b0, code: ps2_data};
    if (ps2_data_en) begin
      if (state_q == S_PAUSE) begin
        // Every tail byte counts, including ones that look like responses.
        skip_d = skip_q - SKIP_W'(1);
        if (skip_q <= SKIP_W'(1)) begin
          make_fire = 1'b1;
          evt.code  = PS2_PREFIX_PAUSE;
          state_d   = S_IDLE;
        end
      end else if (is_response(ps2_data)) begin
        state_d = S_IDLE;
      end else if (ps2_data == PS2_PREFIX_EXT) begin
        state_d = S_E0;
      end else if (ps2_data == PS2_PREFIX_BRK) begin
        state_d = (state_q == S_E0 || state_q == S_E0F0) ? S_E0F0 : S_F0;
      end else if (ps2_data == PS2_PREFIX_PAUSE && state_q == S_IDLE) begin
        state_d = S_PAUSE;
        skip_d  = SKIP_W'(PAUSE_TAIL_LEN);
      end else begin
        state_d = S_IDLE;
        case (state_q)
          S_IDLE: make_fire = 1'b1;
          S_E0: begin
            make_fire = 1'b1;
            evt.ext   = 1'b1;
          end
          S_F0:   brk_fire = 1'b1;
          S_E0F0: begin
            brk_fire = 1'b1;
            evt.ext  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  key_event_t held_q;
  logic       held_vld_q;
  logic       repeat_hit;

  assign repeat_hit = held_vld_q && (held_q == evt);
  assign push_req   = make_fire && !repeat_hit;

  // The tracker follows accepted makes even when the FIFO drops them.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else if (make_fire && !repeat_hit) begin
      held_q     <= evt;
      held_vld_q <= 1'b1;
    end else if (brk_fire && repeat_hit) begin
      held_vld_q <= 1'b0;
    end
  end
`else
  logic unused_brk_fire;

  assign unused_brk_fire = brk_fire;
  assign push_req        = make_fire;
`endif

  assign pop_fire = key_valid && key_ready;

  scancode_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_req),
    .wr_data (evt),
    .pop     (key_ready),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop_fire) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  assign key_valid    = !fifo_empty;
  assign key_code     = head.code;
  assign key_extended = head.ext;

endmodule

// File: tb/tb_ps2_make_code_filter.sv
// Self-checking bench: directed vector table, hand sequences for overflow,
// typematic and reset corners, then random bytes against a queue-based model.
module tb_ps2_make_code_filter;

  localparam int DEPTH = 4;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam int EXP_REP = 2;
  localparam bit FILTER  = 1'b1;
`else
  localparam int EXP_REP = 4;
  localparam bit FILTER  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_data_en = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       key_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       overflow;
  logic [2:0] fifo_count;

  ps2_make_code_filter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .ps2_data_en    (ps2_data_en),
    .ps2_data       (ps2_data),
    .key_ready      (key_ready),
    .clear_overflow (clear_overflow),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_extended   (key_extended),
    .overflow       (overflow),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input bit v, input logic [7:0] c,
                           input bit e, input int cnt, input bit o);
    check({tag, ".valid"}, 32'(key_valid), 32'(v));
    check({tag, ".code"},  32'(key_code),  32'(c));
    check({tag, ".ext"},   32'(key_extended), 32'(e));
    check({tag, ".count"}, 32'(fifo_count), 32'(cnt));
    check({tag, ".ovf"},   32'(overflow),  32'(o));
  endtask

  // One clock: inputs change at the falling edge, outputs sampled 1 after the rising edge.
  task automatic cycle(input bit en, input logic [7:0] d, input bit rdy,
                       input bit clr, input bit rst);
    @(negedge clk);
    ps2_data_en    = en;
    ps2_data       = d;
    key_ready      = rdy;
    clear_overflow = clr;
    reset          = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit rdy);
    cycle(1'b1, d, rdy, 1'b0, 1'b0);
  endtask

  // ---------------- reference model: prefix flags + event queue ----------------
  bit         m_ext_pend, m_brk_pend;
  int         m_pause_left;
  logic [8:0] m_q[$];
  bit         m_ovf;
  bit         m_held_v;
  logic [8:0] m_held;

  function automatic bit is_resp(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
           b == 8'hFC || b == 8'hFE || b == 8'hFF;
  endfunction

  task automatic model_step(input bit en, input logic [7:0] d, input bit rdy,
                            input bit clr, input bit rst);
    bit         has_make = 1'b0;
    bit         has_brk  = 1'b0;
    bit         pop;
    bit         ovf_set  = 1'b0;
    logic [8:0] ev = 9'h000;
    if (rst) begin
      m_ext_pend = 0; m_brk_pend = 0; m_pause_left = 0;
      m_q.delete(); m_ovf = 0; m_held_v = 0; m_held = 9'h000;
      return;
    end
    pop = (m_q.size() > 0) && rdy;
    if (en) begin
      if (m_pause_left > 0) begin
        m_pause_left--;
        if (m_pause_left == 0) begin
          has_make = 1'b1;
          ev = {1'b0, 8'hE1};
        end
      end else if (is_resp(d)) begin
        m_ext_pend = 0; m_brk_pend = 0;
      end else if (d == 8'hE0) begin
        m_ext_pend = 1; m_brk_pend = 0;
      end else if (d == 8'hF0) begin
        m_brk_pend = 1;
      end else if (d == 8'hE1 && !m_ext_pend && !m_brk_pend) begin
        m_pause_left = 7;
      end else begin
        ev = {m_ext_pend, d};
        if (m_brk_pend) has_brk = 1'b1;
        else has_make = 1'b1;
        m_ext_pend = 0; m_brk_pend = 0;
      end
    end
    if (FILTER) begin
      if (has_make) begin
        if (m_held_v && m_held == ev) has_make = 1'b0;
        else begin
          m_held = ev;
          m_held_v = 1'b1;
        end
      end
      if (has_brk && m_held_v && m_held == ev) m_held_v = 1'b0;
    end
    if (pop) void'(m_q.pop_front());
    if (has_make) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev);
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         en;
    logic [7:0] data;
    bit         rdy;
    bit         exp_valid;
    logic [7:0] exp_code;
    bit         exp_ext;
    int         exp_count;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit en, input logic [7:0] d, input bit rdy,
                     input bit v, input logic [7:0] c, input bit e, input int cnt);
    vec_t t;
    t.en = en; t.data = d; t.rdy = rdy;
    t.exp_valid = v; t.exp_code = c; t.exp_ext = e; t.exp_count = cnt;
    tbl.push_back(t);
  endtask

  initial begin
    // Make then break with consumer ready: one event visible for one cycle.
    add(1, 8'h1C, 1, 1, 8'h1C, 0, 1);
    add(1, 8'hF0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h1C, 1, 0, 8'h00, 0, 0);
    // Extended make and extended break, consumer stalled.
    add(1, 8'hE0, 0, 0, 8'h00, 0, 0);
    add(1, 8'h75, 0, 1, 8'h75, 1, 1);
    add(1, 8'hE0, 0, 1, 8'h75, 1, 1);
    add(1, 8'hF0, 0, 1, 8'h75, 1, 1);
    add(1, 8'h75, 0, 1, 8'h75, 1, 1);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0);
    // Pause sequence collapses to a single E1 event, then a normal make.
    add(1, 8'hE1, 0, 0, 8'h00, 0, 0);
    add(1, 8'h14, 0, 0, 8'h00, 0, 0);
    add(1, 8'h77, 0, 0, 8'h00, 0, 0);
    add(1, 8'hE1, 0, 0, 8'h00, 0, 0);
    add(1, 8'hF0, 0, 0, 8'h00, 0, 0);
    add(1, 8'h14, 0, 0, 8'h00, 0, 0);
    add(1, 8'hF0, 0, 0, 8'h00, 0, 0);
    add(1, 8'h77, 0, 1, 8'hE1, 0, 1);
    add(1, 8'h16, 0, 1, 8'hE1, 0, 2);
    add(0, 8'h00, 1, 1, 8'h16, 0, 1);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0);
    // A response byte cancels a pending E0 prefix.
    add(1, 8'hE0, 0, 0, 8'h00, 0, 0);
    add(1, 8'hAA, 0, 0, 8'h00, 0, 0);
    add(1, 8'h1C, 0, 1, 8'h1C, 0, 1);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0);

    // Reset state.
    cycle(0, 8'h00, 0, 0, 1);
    check_all("reset", 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].data, tbl[i].rdy, 1'b0, 1'b0);
      check_all($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_code,
                tbl[i].exp_ext, tbl[i].exp_count, 1'b0);
    end

    // Auto-repeat stream: suppressed only when the typematic filter is built in.
    cycle(0, 8'h00, 0, 0, 1);
    send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 0);
    send(8'hF0, 0); send(8'h1C, 0); send(8'h1C, 0);
    check("rep.count", 32'(fifo_count), 32'(EXP_REP));
    for (int i = 0; i < EXP_REP; i++) begin
      check($sformatf("rep.head%0d", i), 32'(key_code), 32'h1C);
      cycle(0, 8'h00, 1, 0, 0);
    end
    check("rep.drained", 32'(key_valid), 32'h0);

    // Overflow, set-wins-over-clear, push+pop while full, ordered drain.
    cycle(0, 8'h00, 0, 0, 1);
    send(8'h15, 0); send(8'h1D, 0); send(8'h24, 0); send(8'h2D, 0);
    check_all("ovf.full", 1, 8'h15, 0, 4, 0);
    send(8'h2C, 0);
    check_all("ovf.drop", 1, 8'h15, 0, 4, 1);
    cycle(1, 8'h3C, 0, 1, 0);
    check_all("ovf.setwins", 1, 8'h15, 0, 4, 1);
    cycle(0, 8'h00, 0, 1, 0);
    check_all("ovf.clear", 1, 8'h15, 0, 4, 0);
    send(8'h35, 1);
    check_all("ovf.pushpop", 1, 8'h1D, 0, 4, 0);
    cycle(0, 8'h00, 1, 0, 0);
    check_all("ovf.pop1", 1, 8'h24, 0, 3, 0);
    cycle(0, 8'h00, 1, 0, 0);
    check_all("ovf.pop2", 1, 8'h2D, 0, 2, 0);
    cycle(0, 8'h00, 1, 0, 0);
    check_all("ovf.pop3", 1, 8'h35, 0, 1, 0);
    cycle(0, 8'h00, 1, 0, 0);
    check_all("ovf.empty", 0, 8'h00, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    check_all("ovf.idlepop", 0, 8'h00, 0, 0, 0);

    // Reset in the middle of a break sequence.
    send(8'hE0, 0); send(8'h5A, 0);
    check_all("mid.ext", 1, 8'h5A, 1, 1, 0);
    send(8'h6B, 0); send(8'hF0, 0);
    cycle(0, 8'h00, 0, 0, 1);
    check_all("mid.reset", 0, 8'h00, 0, 0, 0);
    send(8'h29, 0);
    check_all("mid.after", 1, 8'h29, 0, 1, 0);

    // Random traffic against the model.
    model_step(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      bit         en  = ($urandom_range(0, 3) != 0);
      bit         rdy = ($urandom_range(0, 1) != 0);
      bit         clr = ($urandom_range(0, 29) == 0);
      bit         rst = ($urandom_range(0, 299) == 0);
      logic [7:0] d;
      logic [7:0] resp [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
      logic [7:0] keys [4] = '{8'h1C, 8'h1D, 8'h75, 8'h5A};
      case ($urandom_range(0, 9))
        0:       d = 8'hE0;
        1, 2:    d = 8'hF0;
        3:       d = 8'hE1;
        4:       d = resp[$urandom_range(0, 6)];
        5, 6, 7: d = keys[$urandom_range(0, 3)];
        default: d = 8'($urandom);
      endcase
      model_step(en, d, rdy, clr, rst);
      cycle(en, d, rdy, clr, rst);
      check_all($sformatf("rnd%0d", n), m_q.size() > 0,
                m_q.size() > 0 ? m_q[0][7:0] : 8'h00,
                m_q.size() > 0 ? m_q[0][8] : 1'b0,
                m_q.size(), m_ovf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_make_code_filter.md
# ps2_make_code_filter

Sits between `PS2_Controller` and the game FSM. Turns the raw PS/2 Set-2 byte stream into exactly one event per physical key press. It strips break sequences, prefix bytes and protocol responses. Accepted make codes go into a small show-ahead FIFO with a valid/ready handshake, so the reader FSM consumes one clean keystroke per handshake instead of counting raw strobes.

## Interface
- `FIFO_DEPTH`, default 4: entries in output FIFO; power of two, ≥2.
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: synchronous, active-high.
- `ps2_data_en` in 1: one-cycle strobe, `ps2_data` valid.
- `ps2_data` in 8: received byte from PS2_Controller.
- `key_ready` in 1: consumer accepts head entry this cycle.
- `clear_overflow` in 1: clears `overflow`.
- `key_valid` out 1: FIFO non-empty.
- `key_code` out 8: head entry make code.
- `key_extended` out 1: head entry came from an E0-prefixed make.
- `overflow` out 1: sticky, a make was dropped on full FIFO.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupancy.

## Operation
- Bytes are processed only on cycles where `ps2_data_en`=1.
- Decoder FSM states:
  - S_IDLE
  - S_E0 (extended prefix seen)
  - S_F0 (break prefix seen)
  - S_E0F0 (extended break)
  - S_PAUSE (swallowing Pause tail)
- Transitions and actions per byte:
  - 0xE0: S_IDLE or S_E0 → S_E0.
  - 0xF0: S_IDLE or S_F0 → S_F0; S_E0 or S_E0F0 → S_E0F0.
  - 0xE1 in S_IDLE → S_PAUSE, with the skip counter loaded to 7.
  - Other byte in S_IDLE → make {ext=0}; in S_E0 → make {ext=1}. Next state S_IDLE.
  - Other byte in S_F0 → break {ext=0}; in S_E0F0 → break {ext=1}. Next state S_IDLE; nothing pushed.
- S_PAUSE decrements the counter on each byte. When the counter hits 0, it emits make {0xE1, ext=0} and returns to S_IDLE.
- Response bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF are discarded in every state except S_PAUSE. They force S_IDLE.
- Make events go through the repeat filter (see Configuration), then are pushed.
- FIFO:
  - Push when full: entry dropped, `overflow` set.
  - Pop when `key_valid` && `key_ready`.
  - Push and pop in the same cycle while full: both occur, no overflow, count unchanged.
  - `key_ready` while empty: ignored.
- `overflow` clears on `reset` or `clear_overflow`. If a set and a clear happen in the same cycle, set wins.
- Reset values: FSM S_IDLE, skip counter 0, FIFO empty, held-key tracker empty. Outputs `key_valid`=0, `key_code`=0, `key_extended`=0, `overflow`=0, `fifo_count`=0.
- Reset mid-sequence, e.g. after 0xF0: the partial sequence is lost. The next byte is decoded from S_IDLE.

## Timing
- Final byte of a make sampled at edge N (strobe high in cycle N−1..N): the entry is written at edge N; `key_valid`=1 from cycle N onward. One-cycle latency from strobe to valid.
- Show-ahead: `key_code`/`key_extended` are the head entry combinationally, stable while `key_valid` && !`key_ready`.
- Pop at edge M: the next entry, or `key_valid`=0, is visible in cycle M+1.
- Back-to-back strobes on consecutive cycles are each processed; no byte is dropped by the decoder.
- `fifo_count` updates on the same edge as the push/pop.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN`, when defined:
  - A held register stores {ext, code} of the last accepted make, plus a valid bit.
  - A make equal to the held value is discarded (keyboard auto-repeat).
  - A break equal to the held value clears the valid bit.
  - A different make is pushed and replaces the held value.
  - Reset clears the tracker.
- When not defined: the held register is absent, and every make, including auto-repeats, is pushed.

## Structure
- Package `ps2_scancode_pkg`:
  - prefix constants PS2_PREFIX_EXT 8'hE0, PS2_PREFIX_BRK 8'hF0, PS2_PREFIX_PAUSE 8'hE1
  - response-byte constants
  - PAUSE_TAIL_LEN 7
  - decoder state enum
- Sub-module `scancode_fifo`: 9-bit wide (ext, code), parameterised depth, show-ahead, sync active-high reset, reports count/full/empty.
- Decoder FSM, Pause counter and typematic filter stay in the top module.

## Test plan
- Stream 1C, F0, 1C with `key_ready`=1 → exactly one event: `key_code`=0x1C, `key_extended`=0, valid for 1 cycle.
- Stream E0, 75, E0, F0, 75 → one event: 0x75 with `key_extended`=1; break produces nothing.
- Macro defined, stream 1C, 1C, 1C, F0, 1C, 1C → two 0x1C events. Macro undefined → four events.
- E1 14 77 E1 F0 14 F0 77 → single event 0xE1 ext=0. Then 0x16 → event 0x16.
- `key_ready`=0, push 5 makes with FIFO_DEPTH=4 → `fifo_count`=4, `overflow`=1, heads pop in order 1st..4th. `clear_overflow` → `overflow`=0.
- Send F0, assert `reset` one cycle, send 29 → event 0x29, not suppressed as break. All outputs 0 during reset.
